// File: rtl/wb_dma_hs_pkg.sv
// Shared types and helpers for the DMA hardware-handshake arbiter.
// Optional engine timeout is enabled by defining WB_DMA_HS_TIMEOUT_EN.
package wb_dma_hs_pkg;

  localparam int DEF_NCH     = 32;
  localparam int DEF_CHW     = 5;
  localparam int DEF_TMO_CYC = 1024;
  localparam int MAX_NCH     = 32;
  localparam int MAX_CHW     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } hs_state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_CHW-1:0] idx;
  } rr_pick_t;

  // First set bit of vec at or above ptr, wrapping at nch-1; ptr must be < nch.
  function automatic rr_pick_t rr_pick(input logic [MAX_NCH-1:0] vec,
                                       input logic [MAX_CHW-1:0] ptr,
                                       input int                 nch);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int i = 0; i < MAX_NCH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= nch) idx = idx - nch;
      if (i < nch) begin
        if (!r.found && vec[idx]) begin
          r.found = 1'b1;
          r.idx   = idx[MAX_CHW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_dma_hs_rr_pick.sv
// Combinational round-robin priority finder: first request at or above the
// pointer, wrapping; shared with the register-mode channel arbiter.
import wb_dma_hs_pkg::*;

module wb_dma_hs_rr_pick #(
  parameter int NCH = DEF_NCH,
  parameter int CHW = DEF_CHW
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic           found,
  output logic [CHW-1:0] idx
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_NCH'(req), MAX_CHW'(ptr), NCH);
    found = pick.found;
    idx   = CHW'(pick.idx);
  end

endmodule

// File: rtl/wb_dma_hs_arb.sv
// Hardware-handshake arbiter/sequencer in front of the DMA engine service port.
// Define WB_DMA_HS_TIMEOUT_EN to add the engine-response timeout and tmo_o.
import wb_dma_hs_pkg::*;

module wb_dma_hs_arb #(
  parameter int NCH     = DEF_NCH,
  parameter int CHW     = DEF_CHW,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [NCH-1:0] ch_en_i,
  input  logic [NCH-1:0] dma_req_i,
  input  logic [NCH-1:0] dma_nd_i,
  input  logic [NCH-1:0] dma_rest_i,
  output logic [NCH-1:0] dma_ack_o,
  output logic           eng_req_o,
  output logic [CHW-1:0] eng_ch_o,
  output logic           eng_nd_o,
  input  logic           eng_done_i,
  output logic           eng_abort_o,
  output logic           busy_o
`ifdef WB_DMA_HS_TIMEOUT_EN
  ,
  output logic           tmo_o
`endif
);

  if (CHW != $clog2(NCH) || NCH < 2 || NCH > MAX_NCH || TMO_CYC < 2) begin : g_bad_param
    $error("wb_dma_hs_arb: inconsistent NCH/CHW/TMO_CYC");
  end

  // Handshake: eng_req_o is a level held from grant until the engine returns
  // a one-cycle eng_done_i; eng_abort_o and dma_ack_o are one-cycle pulses.
  hs_state_e      state, state_n;
  logic [CHW-1:0] rr_ptr, rr_ptr_n, ch_n, win;
  logic [NCH-1:0] blocked, blocked_n, elig;
  logic           found, nd_n, abort_n;

`ifdef WB_DMA_HS_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC);
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic          tmo_n;
`endif

  assign elig = dma_req_i & ch_en_i & ~dma_rest_i & ~blocked;

  wb_dma_hs_rr_pick #(.NCH(NCH), .CHW(CHW)) u_pick (
    .req   (elig),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (win)
  );

  assign eng_req_o = (state == GRANT);
  assign busy_o    = (state != IDLE);
  assign dma_ack_o = (state == ACK) ? (NCH'(1) << eng_ch_o) : '0;

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    ch_n     = eng_ch_o;
    nd_n     = eng_nd_o;
    abort_n  = 1'b0;
    // A block lasts until the peripheral drops its request or restarts.
    blocked_n = blocked & dma_req_i & ~dma_rest_i;
`ifdef WB_DMA_HS_TIMEOUT_EN
    tmo_cnt_n = tmo_cnt;
    tmo_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        nd_n = 1'b0;
        if (found) begin
          state_n  = GRANT;
          ch_n     = win;
          nd_n     = dma_nd_i[win];
          rr_ptr_n = (win == CHW'(NCH - 1)) ? '0 : win + 1'b1;
`ifdef WB_DMA_HS_TIMEOUT_EN
          tmo_cnt_n = '0;
`endif
        end
      end
      GRANT: begin
        if (eng_done_i) begin
          state_n = ACK;
        end else if (dma_rest_i[eng_ch_o]) begin
          state_n = IDLE;
          abort_n = 1'b1;
          nd_n    = 1'b0;
        end
`ifdef WB_DMA_HS_TIMEOUT_EN
        else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
          state_n            = IDLE;
          abort_n            = 1'b1;
          tmo_n              = 1'b1;
          nd_n               = 1'b0;
          blocked_n[eng_ch_o] = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
`endif
      end
      ACK: begin
        blocked_n[eng_ch_o] = 1'b1;
        state_n             = IDLE;
        nd_n                = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      blocked     <= '0;
      eng_ch_o    <= '0;
      eng_nd_o    <= 1'b0;
      eng_abort_o <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_ptr_n;
      blocked     <= blocked_n;
      eng_ch_o    <= ch_n;
      eng_nd_o    <= nd_n;
      eng_abort_o <= abort_n;
    end
  end

`ifdef WB_DMA_HS_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
      tmo_o   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
      tmo_o   <= tmo_n;
    end
  end
`endif

endmodule

// File: tb/tb_wb_dma_hs_arb.sv
// Directed bench for wb_dma_hs_arb with NCH=4; timeout section is built only
// when WB_DMA_HS_TIMEOUT_EN is defined.
module tb_wb_dma_hs_arb;

  localparam int NCH     = 4;
  localparam int CHW     = 2;
  localparam int TMO_CYC = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] ch_en, dma_req, dma_nd, dma_rest, dma_ack;
  logic           eng_req, eng_nd, eng_done, eng_abort, busy;
  logic [CHW-1:0] eng_ch;
`ifdef WB_DMA_HS_TIMEOUT_EN
  logic           tmo;
`endif

  int             checks = 0;
  int             errors = 0;
  logic [CHW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  wb_dma_hs_arb #(.NCH(NCH), .CHW(CHW), .TMO_CYC(TMO_CYC)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ch_en_i     (ch_en),
    .dma_req_i   (dma_req),
    .dma_nd_i    (dma_nd),
    .dma_rest_i  (dma_rest),
    .dma_ack_o   (dma_ack),
    .eng_req_o   (eng_req),
    .eng_ch_o    (eng_ch),
    .eng_nd_o    (eng_nd),
    .eng_done_i  (eng_done),
    .eng_abort_o (eng_abort),
    .busy_o      (busy)
`ifdef WB_DMA_HS_TIMEOUT_EN
    ,
    .tmo_o       (tmo)
`endif
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"}, eng_req, 0);
    check({tag, "_ch"}, eng_ch, 0);
    check({tag, "_nd"}, eng_nd, 0);
    check({tag, "_ack"}, dma_ack, 0);
    check({tag, "_abort"}, eng_abort, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Serve the next grant from the expected queue; the peripheral drops its
  // request on ack and optionally re-raises it two cycles later.
  task automatic serve_rr(input bit reraise);
    logic [CHW-1:0] exp_ch;
    logic [NCH-1:0] one;
    int             n;
    exp_ch = exp_q.pop_front();
    one    = 4'b0001;
    n      = 0;
    while (eng_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("rr_req", eng_req, 1);
    check("rr_ch", eng_ch, exp_ch);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("rr_ack", dma_ack, one << exp_ch);
    dma_req[exp_ch] = 1'b0;
    tick();
    tick();
    if (reraise) dma_req[exp_ch] = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    ch_en    = '0;
    dma_req  = '0;
    dma_nd   = '0;
    dma_rest = '0;
    eng_done = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    // first grant after reset, then asynchronous reset mid-GRANT
    ch_en   = 4'hf;
    dma_req = 4'b0100;
    tick();
    check("first_req", eng_req, 1);
    check("first_ch", eng_ch, 2);
    check("first_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    dma_req = '0;
    rst     = 1'b0;
    tick();
    check("rst_no_abort", eng_abort, 0);
    check("rst_idle", busy, 0);

    // round robin 0,1,2,3,0
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    dma_req = 4'hf;
    serve_rr(1'b1);
    serve_rr(1'b0);
    serve_rr(1'b0);
    serve_rr(1'b0);
    serve_rr(1'b0);
    check("rr_drained", busy, 0);

    // blocking: ch1 holds request after ack
    dma_req = 4'b0010;
    tick();
    check("blk_grant_ch", eng_ch, 1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("blk_ack", dma_ack, 4'b0010);
    tick();
    check("blk_hold0", eng_req, 0);
    tick();
    check("blk_hold1", eng_req, 0);
    tick();
    check("blk_hold2", eng_req, 0);
    dma_req = 4'b0000;
    tick();
    dma_req = 4'b0010;
    tick();
    check("blk_regrant_req", eng_req, 1);
    check("blk_regrant_ch", eng_ch, 1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    dma_req  = '0;
    tick();

    // next-descriptor flag held through GRANT, cleared in IDLE
    dma_req = 4'b1000;
    dma_nd  = 4'b1000;
    tick();
    check("nd_grant", eng_nd, 1);
    dma_nd = '0;
    tick();
    check("nd_held", eng_nd, 1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    dma_req  = '0;
    tick();
    check("nd_idle", eng_nd, 0);

    // restart abort, then done and rest together
    dma_req = 4'b0100;
    tick();
    check("abt_grant_ch", eng_ch, 2);
    dma_rest = 4'b0100;
    tick();
    check("abt_pulse", eng_abort, 1);
    check("abt_req", eng_req, 0);
    check("abt_no_ack", dma_ack, 0);
    dma_rest = '0;
    tick();
    check("abt_one_cycle", eng_abort, 0);
    check("abt_regrant", eng_req, 1);
    check("abt_regrant_ch", eng_ch, 2);
    eng_done = 1'b1;
    dma_rest = 4'b0100;
    tick();
    check("both_ack", dma_ack, 4'b0100);
    check("both_no_abort", eng_abort, 0);
    eng_done = 1'b0;
    dma_rest = '0;
    dma_req  = '0;
    tick();
    check("both_after_ack", dma_ack, 0);
    check("both_after_abort", eng_abort, 0);

    // enable dropped while granted: transfer still completes
    dma_req = 4'b0001;
    tick();
    ch_en = '0;
    tick();
    check("en_hold_req", eng_req, 1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("en_ack", dma_ack, 4'b0001);
    dma_req = '0;
    ch_en   = 4'hf;
    tick();
    tick();

`ifdef WB_DMA_HS_TIMEOUT_EN
    // engine never answers: abort and tmo after TMO_CYC clocks in GRANT
    dma_req = 4'b0001;
    tick();
    check("tmo_grant_ch", eng_ch, 0);
    for (int i = 0; i < TMO_CYC - 1; i++) tick();
    check("tmo_not_yet_req", eng_req, 1);
    check("tmo_not_yet_abort", eng_abort, 0);
    tick();
    check("tmo_abort", eng_abort, 1);
    check("tmo_flag", tmo, 1);
    check("tmo_req_low", eng_req, 0);
    tick();
    check("tmo_flag_pulse", tmo, 0);
    tick();
    check("tmo_blocked", eng_req, 0);
    dma_req = '0;
    tick();
    dma_req = 4'b0001;
    tick();
    check("tmo_regrant", eng_req, 1);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    dma_req  = '0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dma_hs_arb.md
Name: wb_dma_hs_arb

Overview:
- Arbiter and sequencer between the per-channel hardware handshake lines (dma_req/dma_ack/dma_nd/dma_rest) and the DMA engine's single channel-service port.
- Picks one requesting, enabled channel round-robin and presents it to the engine with its next-descriptor flag.
- Returns a one-cycle dma_ack to the served peripheral when the engine finishes.
- Handles dma_rest aborts.

Parameters:
- NCH, 32, number of handshake channels (2..32)
- CHW, 5, width of channel index; must equal clog2(NCH)
- TMO_CYC, 1024, engine-response timeout in clocks; used only with the optional feature

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- ch_en_i  in  NCH  per-channel hardware-handshake enable from the register file
- dma_req_i  in  NCH  peripheral requests, level
- dma_nd_i  in  NCH  next-descriptor request, sampled with grant
- dma_rest_i  in  NCH  restart/abort request, level
- dma_ack_o  out  NCH  one-hot, one-cycle acknowledge to peripheral
- eng_req_o  out  1  service request to engine
- eng_ch_o  out  CHW  granted channel index
- eng_nd_o  out  1  latched dma_nd of granted channel
- eng_done_i  in  1  engine finished the granted transfer (1-cycle pulse)
- eng_abort_o  out  1  one-cycle abort to engine
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async on rst_i high):
  - state=IDLE; rr_ptr=0; blocked=0
  - all outputs 0: eng_req_o, eng_ch_o, eng_nd_o, dma_ack_o, eng_abort_o, busy_o
- Eligibility: elig = dma_req_i & ch_en_i & ~dma_rest_i & ~blocked.
- Arbitration: round-robin. Scan from rr_ptr upward with wrap at NCH-1 to 0; the first set elig bit wins.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - If elig != 0: go to GRANT. Register win to eng_ch_o, dma_nd_i[win] to eng_nd_o, set eng_req_o=1, set rr_ptr = (win+1) mod NCH.
  - Latency: eng_req_o rises 1 clock after elig bit seen high.
- GRANT:
  - eng_req_o, eng_ch_o, eng_nd_o held stable.
  - eng_done_i=1 -> ACK; eng_req_o=0 next cycle.
  - Else dma_rest_i[eng_ch_o]=1 -> IDLE. eng_abort_o=1 for exactly one cycle, eng_req_o=0, no ack, channel not blocked.
  - eng_done_i and rest in the same cycle: done wins, ack issued.
- ACK (1 cycle):
  - dma_ack_o[eng_ch_o]=1 for one cycle; blocked[eng_ch_o] set.
  - Next state IDLE unconditionally.
- Blocked clear: blocked[k] clears on any cycle with dma_req_i[k]=0 or dma_rest_i[k]=1. Prevents re-serving a request the peripheral has not yet dropped after ack.
- ch_en_i deassert while granted: transfer completes normally. Enable affects eligibility only.
- Back-to-back service: min 3 clocks per grant (IDLE, GRANT with done, ACK).
- eng_ch_o retains last value in IDLE; eng_nd_o cleared in IDLE.
- Reset mid-GRANT: immediate return to reset values; no abort pulse.

Optional Feature:
- Macro: WB_DMA_HS_TIMEOUT_EN.
- When defined:
  - Counter clears on GRANT entry and counts in GRANT.
  - When it reaches TMO_CYC-1 without eng_done_i: eng_abort_o pulses one cycle, state -> IDLE, blocked[eng_ch_o] set.
  - Extra output tmo_o (1 bit) pulses with the abort. Reset value 0.
- When undefined: no counter, no tmo_o port; GRANT waits indefinitely.

Decomposition:
- Package wb_dma_hs_pkg:
  - state enum typedef (IDLE, GRANT, ACK)
  - default NCH/CHW/TMO_CYC constants
  - function rr_pick(vec, ptr) returning a valid bit and an index
- Sub-module wb_dma_hs_rr_pick: combinational round-robin priority finder (NCH-wide request vector plus pointer in; found flag plus index out). Reused by the register-mode channel arbiter.

Test Plan (NCH=4):
- Reset: hold rst_i mid-stream -> all outputs 0 asynchronously; after release first req on ch2 -> eng_req_o=1, eng_ch_o=2 next clock.
- Round-robin: ch0..ch3 req high and enabled; done pulsed each grant; peripherals drop req on ack -> grant order 0,1,2,3,0; dma_ack_o one-hot 1,2,4,8.
- Blocking: ch1 keeps req high after ack, others idle -> no re-grant until ch1 req low for ≥1 clock, then re-grant.
- Next-descriptor: ch3 req with dma_nd_i[3]=1 -> eng_nd_o=1 held through GRANT; 0 in IDLE.
- Abort: ch2 granted, dma_rest_i[2]=1 -> eng_abort_o 1-cycle pulse, no dma_ack_o; done and rest in the same cycle -> dma_ack_o[2] pulse, no abort.
- Timeout (WB_DMA_HS_TIMEOUT_EN, TMO_CYC=8): grant ch0, never done -> eng_abort_o and tmo_o 8 clocks after GRANT entry; ch0 blocked until req drops.
